thread_pc_sequencer: RTL and testbench
======================================

# thread_pc_sequencer

Upstream feeder for the CPU fetch stage: holds one program counter per hardware thread, picks the next enabled thread round-robin, and issues a single-word read request to fetch. It also captures the returned instruction word and presents it to decode together with its PC and thread id over a valid/ready handshake. It supports per-thread PC redirect (branch/jump/exception) with squash of in-flight instructions; exactly one fetch is outstanding at a time.

## Interface
- THREADS, 4: number of hardware threads; thread id is 2 bits. Only 4 is supported.
- RESET_PC, 32'h0000_0000: value loaded into every thread PC at reset.
- PC_STEP, 4: PC increment per fetched instruction.

- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset. This is the one clock; reset is asynchronous and active-low.
- thread_en  in  4  per-thread run mask; bit t=1 makes thread t eligible.
- redirect_valid  in  1  load redirect_pc into PC[redirect_thread] this cycle.
- redirect_thread  in  2  target thread of redirect.
- redirect_pc  in  32  new PC.
- f_enable  out  1  fetch request; held high until f_ack.
- f_write  out  1  write-mode select to fetch; constant 0.
- f_addr  out  32  fetch address (PC of selected thread).
- f_wdata  out  32  write data to fetch; constant 0.
- f_thread  out  2  thread id of request.
- f_data  in  32  instruction word from fetch, valid when f_ack=1.
- f_ack  in  1  fetch completion, one cycle per request.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst_data  out  32  instruction word.
- inst_pc  out  32  PC of inst_data.
- inst_thread  out  2  thread id of inst_data.

## Operation
- State: PC[0..3] (32 bit), rr_last (2 bit), FSM {IDLE, REQ, HOLD}, discard flag.
- Thread pick: first enabled thread scanning rr_last+1, rr_last+2, ... (mod 4); rr_last updated to picked thread when a request is issued.
- IDLE: if any thread_en bit set -> REQ with f_enable=1, f_addr=PC[pick], f_thread=pick; else stay.
- REQ: f_enable, f_addr, f_thread stable. On f_ack=1: if not discard, inst_data<=f_data, inst_pc<=f_addr, inst_thread<=f_thread, PC[f_thread]<=f_addr+PC_STEP, -> HOLD; if discard, drop word, PC unchanged, clear discard, -> IDLE.
- HOLD: inst_valid=1, outputs stable. On inst_ready=1: if any thread enabled, issue next request directly (-> REQ), else -> IDLE.
- Redirect: PC[redirect_thread]<=redirect_pc, always, any state.
  - REQ and redirect_thread==f_thread: request still completes (no abort); discard set; word dropped at ack.
  - f_ack and redirect for same thread in same cycle: word dropped, PC=redirect_pc (redirect beats increment).
  - HOLD, redirect_thread==inst_thread, inst_ready=0: inst_valid cleared next edge, -> IDLE.
  - HOLD, same thread, inst_ready=1 same cycle: transfer counts as accepted; PC takes redirect_pc.
- thread_en drop for a thread in REQ/HOLD: in-flight instruction completes and is delivered normally.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values (async, immediate): FSM=IDLE, f_enable=0, f_write=0, f_addr=0, f_wdata=0, f_thread=0, inst_valid=0, inst_data=0, inst_pc=0, inst_thread=0, all PC=RESET_PC, rr_last=3 (thread 0 first), discard=0.
- Reset asserted mid-REQ/HOLD: outputs go to reset values at once; pending fetch is abandoned.
- All outputs registered; no combinational path input->output.
- IDLE with thread_en!=0 at edge N -> f_enable=1 after edge N.
- f_ack sampled at edge M -> f_enable=0 and inst_valid=1 after edge M.
- inst_valid&inst_ready at edge K -> next f_enable=1 after edge K (if a thread is enabled).
- With 1-cycle ack and inst_ready tied high: one instruction per 2 cycles.

## Test plan
- Reset, thread_en=4'b0001, fetch acks 1 cycle after f_enable with f_data=32'hA0+addr -> addresses 0,4,8 on thread 0; inst_pc 0,4,8; inst_data 32'hA0,32'hA4,32'hA8.
- thread_en=4'b1011, RESET_PC=0 -> f_thread sequence 0,1,3,0,1,3; per-thread PCs each advance 0,4,8.
- Thread 1 in REQ, redirect_valid thread 1 pc=32'h100 -> acked word never appears on inst_valid; next thread-1 fetch at 32'h100.
- HOLD with inst_ready=0 for 5 cycles -> inst_valid/inst_data/inst_pc stable, f_enable=0; redirect same thread -> inst_valid=0 next cycle.
- redirect thread 0 pc=32'hFFFF_FFFC -> fetches at 32'hFFFF_FFFC then 32'h0000_0000.
- rst_n low during REQ -> f_enable and inst_valid drop without clock; after release, first fetch is thread 0 at RESET_PC.

Source files
------------

// File: rtl/thread_pc_sequencer.sv
// Per-thread PC holder and round-robin fetch issuer; captures the returned word
// and presents it to decode. One fetch outstanding at a time.
module thread_pc_sequencer #(
  parameter int          THREADS  = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  thread_en_i,
  input  logic        redirect_valid_i,
  input  logic [1:0]  redirect_thread_i,
  input  logic [31:0] redirect_pc_i,
  output logic        f_enable_o,
  output logic        f_write_o,
  output logic [31:0] f_addr_o,
  output logic [31:0] f_wdata_o,
  output logic [1:0]  f_thread_o,
  input  logic [31:0] f_data_i,
  input  logic        f_ack_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_data_o,
  output logic [31:0] inst_pc_o,
  output logic [1:0]  inst_thread_o
);

  // state | meaning
  // IDLE  | no request outstanding, waiting for an enabled thread
  // REQ   | fetch request held until f_ack
  // HOLD  | instruction presented to decode until inst_ready
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q [THREADS];
  logic [31:0] pc_d [THREADS];
  logic [1:0]  rr_last_q, rr_last_d;
  logic        discard_q, discard_d;
  logic        f_enable_q, f_enable_d;
  logic [31:0] f_addr_q, f_addr_d;
  logic [1:0]  f_thread_q, f_thread_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [1:0]  inst_thread_q, inst_thread_d;

  logic [1:0]  pick;
  logic        any_en;
  logic        issue;
  logic        redir_req_hit;
  logic        redir_hold_hit;

  assign any_en         = |thread_en_i;
  assign redir_req_hit  = redirect_valid_i && (redirect_thread_i == f_thread_q);
  assign redir_hold_hit = redirect_valid_i && (redirect_thread_i == inst_thread_q);

  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = rr_last_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= THREADS; i++) begin
      idx = rr_last_q + 2'(i);
      if (!found && thread_en_i[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rr_last_d     = rr_last_q;
    discard_d     = discard_q;
    f_enable_d    = f_enable_q;
    f_addr_d      = f_addr_q;
    f_thread_d    = f_thread_q;
    inst_valid_d  = inst_valid_q;
    inst_data_d   = inst_data_q;
    inst_pc_d     = inst_pc_q;
    inst_thread_d = inst_thread_q;
    issue         = 1'b0;

    case (state_q)
      IDLE: issue = any_en;
      REQ: begin
        if (f_ack_i) begin
          f_enable_d = 1'b0;
          if (discard_q || redir_req_hit) begin
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            inst_data_d       = f_data_i;
            inst_pc_d         = f_addr_q;
            inst_thread_d     = f_thread_q;
            inst_valid_d      = 1'b1;
            pc_d[f_thread_q]  = f_addr_q + PC_STEP;
            state_d           = HOLD;
          end
        end else if (redir_req_hit) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (inst_ready_i) begin
          inst_valid_d = 1'b0;
          if (any_en) issue = 1'b1;
          else        state_d = IDLE;
        end else if (redir_hold_hit) begin
          inst_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect landing on the picked thread in the issue cycle is forwarded.
    if (issue) begin
      state_d    = REQ;
      f_enable_d = 1'b1;
      f_thread_d = pick;
      f_addr_d   = (redirect_valid_i && redirect_thread_i == pick) ? redirect_pc_i : pc_q[pick];
      rr_last_d  = pick;
    end

    if (redirect_valid_i) pc_d[redirect_thread_i] = redirect_pc_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      for (int t = 0; t < THREADS; t++) pc_q[t] <= RESET_PC;
      rr_last_q     <= 2'd3;
      discard_q     <= 1'b0;
      f_enable_q    <= 1'b0;
      f_addr_q      <= '0;
      f_thread_q    <= '0;
      inst_valid_q  <= 1'b0;
      inst_data_q   <= '0;
      inst_pc_q     <= '0;
      inst_thread_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rr_last_q     <= rr_last_d;
      discard_q     <= discard_d;
      f_enable_q    <= f_enable_d;
      f_addr_q      <= f_addr_d;
      f_thread_q    <= f_thread_d;
      inst_valid_q  <= inst_valid_d;
      inst_data_q   <= inst_data_d;
      inst_pc_q     <= inst_pc_d;
      inst_thread_q <= inst_thread_d;
    end
  end

  assign f_enable_o    = f_enable_q;
  assign f_write_o     = 1'b0;
  assign f_addr_o      = f_addr_q;
  assign f_wdata_o     = '0;
  assign f_thread_o    = f_thread_q;
  assign inst_valid_o  = inst_valid_q;
  assign inst_data_o   = inst_data_q;
  assign inst_pc_o     = inst_pc_q;
  assign inst_thread_o = inst_thread_q;

endmodule

// File: tb/tb_thread_pc_sequencer.sv
// Scenario bench for thread_pc_sequencer: a fetch responder pushes expected
// words to a scoreboard, the decode side pops and compares them.
module tb_thread_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  thread_en;
  logic        redirect_valid;
  logic [1:0]  redirect_thread;
  logic [31:0] redirect_pc;
  logic        f_enable, f_write, f_ack, inst_valid, inst_ready;
  logic [31:0] f_addr, f_wdata, f_data, inst_data, inst_pc;
  logic [1:0]  f_thread, inst_thread;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic [1:0]  thr;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  thread_pc_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .thread_en_i(thread_en),
    .redirect_valid_i(redirect_valid), .redirect_thread_i(redirect_thread),
    .redirect_pc_i(redirect_pc), .f_enable_o(f_enable), .f_write_o(f_write),
    .f_addr_o(f_addr), .f_wdata_o(f_wdata), .f_thread_o(f_thread),
    .f_data_i(f_data), .f_ack_i(f_ack), .inst_valid_o(inst_valid),
    .inst_ready_i(inst_ready), .inst_data_o(inst_data), .inst_pc_o(inst_pc),
    .inst_thread_o(inst_thread)
  );

  task automatic apply_reset();
    rst_n = 1'b0; thread_en = '0; redirect_valid = 1'b0; redirect_thread = '0;
    redirect_pc = '0; f_ack = 1'b0; f_data = '0; inst_ready = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for a request, checks it, acks it one cycle later and records the
  // word that decode should later see.
  task automatic serve(input logic [31:0] a, input logic [1:0] t);
    int c = 0;
    while (f_enable !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (f_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL serve_wait: f_enable=%b required 1", f_enable);
    end
    n_checks++;
    if (f_addr !== a || f_thread !== t) begin
      n_fail++;
      $display("FAIL serve_req: addr=%h thr=%0d required addr=%h thr=%0d", f_addr, f_thread, a, t);
    end
    f_ack  = 1'b1;
    f_data = 32'hA0 + f_addr;
    sb.push_back('{data: 32'hA0 + a, pc: a, thr: t});
    @(negedge clk);
    f_ack  = 1'b0;
    f_data = '0;
  endtask

  task automatic consume();
    int c = 0;
    exp_t e;
    while (inst_valid !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (inst_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL consume_wait: inst_valid=%b sb=%0d required valid with entry", inst_valid, sb.size());
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (inst_data !== e.data || inst_pc !== e.pc || inst_thread !== e.thr || f_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL consume_word: data=%h pc=%h thr=%0d fen=%b required data=%h pc=%h thr=%0d fen=0",
                 inst_data, inst_pc, inst_thread, f_enable, e.data, e.pc, e.thr);
      end
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({f_enable, f_write, inst_valid} !== 3'b000 || f_addr !== 0 || f_wdata !== 0 ||
        f_thread !== 0 || inst_data !== 0 || inst_pc !== 0 || inst_thread !== 0) begin
      n_fail++;
      $display("FAIL reset_values: fen=%b fw=%b iv=%b addr=%h wd=%h ft=%0d id=%h ipc=%h it=%0d required all 0",
               f_enable, f_write, inst_valid, f_addr, f_wdata, f_thread, inst_data, inst_pc, inst_thread);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (f_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_enable: f_enable=%b required 0", f_enable);
    end
  endtask

  task automatic test_single_thread();
    apply_reset();
    thread_en = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      serve(32'(4 * k), 2'd0);
      if (k == 2) thread_en = '0;
      consume();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] thr_seq [3];
    thr_seq[0] = 2'd0; thr_seq[1] = 2'd1; thr_seq[2] = 2'd3;
    apply_reset();
    thread_en = 4'b1011;
    for (int i = 0; i < 9; i++) begin
      serve(32'(4 * (i / 3)), thr_seq[i % 3]);
      if (i == 8) thread_en = '0;
      consume();
    end
  endtask

  task automatic test_redirect_req();
    apply_reset();
    thread_en = 4'b0010;
    serve(32'h0, 2'd1);
    consume();
    n_checks++;
    if (f_enable !== 1'b1 || f_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL redir_pre_req: fen=%b addr=%h required fen=1 addr=00000004", f_enable, f_addr);
    end
    redirect_valid = 1'b1; redirect_thread = 2'd1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    f_ack = 1'b1; f_data = 32'hDEAD_BEEF;
    @(negedge clk);
    f_ack = 1'b0; f_data = '0;
    n_checks++;
    if (inst_valid !== 1'b0 || f_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_req_drop: iv=%b fen=%b required iv=0 fen=0", inst_valid, f_enable);
    end
    serve(32'h100, 2'd1);
    consume();
    // ack and redirect to the same thread in one cycle: word dropped, redirect wins
    f_ack = 1'b1; f_data = 32'h1234_5678;
    redirect_valid = 1'b1; redirect_thread = 2'd1; redirect_pc = 32'h200;
    @(negedge clk);
    f_ack = 1'b0; redirect_valid = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_ack_same_cycle: iv=%b required 0", inst_valid);
    end
    serve(32'h200, 2'd1);
    thread_en = '0;
    consume();
  endtask

  task automatic test_hold_stall();
    apply_reset();
    thread_en = 4'b0001;
    serve(32'h0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (inst_valid !== 1'b1 || inst_data !== 32'hA0 || inst_pc !== 32'h0 || f_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: iv=%b data=%h pc=%h fen=%b required iv=1 data=000000a0 pc=0 fen=0",
                 inst_valid, inst_data, inst_pc, f_enable);
      end
      @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_thread = 2'd0; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    void'(sb.pop_front());
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_redirect_squash: iv=%b required 0", inst_valid);
    end
    serve(32'h40, 2'd0);
    // accept and redirect the same thread together; keep idle so PC is observable
    redirect_valid = 1'b1; redirect_thread = 2'd0; redirect_pc = 32'h80;
    thread_en = '0;
    consume();
    redirect_valid = 1'b0;
    thread_en = 4'b0001;
    serve(32'h80, 2'd0);
    thread_en = '0;
    consume();
  endtask

  task automatic test_wrap();
    apply_reset();
    redirect_valid = 1'b1; redirect_thread = 2'd0; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    thread_en = 4'b0001;
    serve(32'hFFFF_FFFC, 2'd0);
    consume();
    serve(32'h0, 2'd0);
    thread_en = '0;
    consume();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    thread_en = 4'b0001;
    serve(32'h0, 2'd0);
    consume();
    n_checks++;
    if (f_enable !== 1'b1 || f_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL rst_pre_req: fen=%b addr=%h required fen=1 addr=00000004", f_enable, f_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (f_enable !== 1'b0 || f_addr !== 32'h0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async_req: fen=%b addr=%h iv=%b required 0,0,0", f_enable, f_addr, inst_valid);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    serve(32'h0, 2'd0);
    n_checks++;
    if (inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_hold: iv=%b required 1", inst_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async_hold: iv=%b data=%h pc=%h required 0,0,0", inst_valid, inst_data, inst_pc);
    end
    sb.delete();
    thread_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_thread();
    test_round_robin();
    test_redirect_req();
    test_hold_stall();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
